// File: rtl/if_fetch_unit_pkg.sv
// Shared core constants and types for the instruction fetch slice.
package if_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// In-order fetch queue: entries allocated at request time, filled by responses, popped at head.
module fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_alloc,
    input  logic [XLEN-1:0] i_alloc_pc,
    input  logic            i_fill,
    input  logic [ILEN-1:0] i_fill_inst,
    input  logic            i_pop,
    output logic [PW:0]     o_count,
    output logic [PW:0]     o_unfilled,
    output logic            o_head_ready,
    output logic [XLEN-1:0] o_head_pc,
    output logic [ILEN-1:0] o_head_inst
);

    localparam logic [PW:0] PTR_ONE = 1;

    fq_entry_t   r_mem [DEPTH];
    // Pointers carry an extra wrap bit so that full and empty are distinguishable.
    logic [PW:0] r_head;
    logic [PW:0] r_tail;
    logic [PW:0] r_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
        end else begin
            if (i_alloc) r_tail <= r_tail + PTR_ONE;
            if (i_fill)  r_fill <= r_fill + PTR_ONE;
            if (i_pop)   r_head <= r_head + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (i_alloc && !i_flush) r_mem[r_tail[PW-1:0]].pc   <= i_alloc_pc;
        if (i_fill && !i_flush)  r_mem[r_fill[PW-1:0]].inst <= i_fill_inst;
    end

    always_comb begin
        o_count      = r_tail - r_head;
        o_unfilled   = r_tail - r_fill;
        o_head_ready = (r_fill != r_head);
        o_head_pc    = r_mem[r_head[PW-1:0]].pc;
        o_head_inst  = r_mem[r_head[PW-1:0]].inst;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generation, request issue, redirect flush and stale-response dropping.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            if_id_stall,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_inst,
    output logic            if_valid
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_drop;
    logic            r_live;

    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_unfilled;
    logic            w_head_ready;
    logic [XLEN-1:0] w_head_pc;
    logic [ILEN-1:0] w_head_inst;
    logic            w_rsp;
    logic            w_pop;
    logic            w_room;
    logic            w_alloc;
    logic            w_fill;
    logic [OW-1:0]   w_occ;
    logic [CW-1:0]   w_pending;
    logic [CW-1:0]   w_drop_d;

    always_comb begin
        // Nothing is in flight in the first cycle out of reset, so any response then is stale.
        w_rsp     = imem_rsp_valid && r_live;
        w_pop     = w_head_ready && !if_id_stall && !redirect_valid;
        // Dropped in-flight requests still occupy memory-side slots, so they count toward room.
        w_occ     = OW'(r_drop) + OW'(w_count) - OW'(w_pop);
        w_room    = (w_occ < OW'(FQ_DEPTH));
        imem_req_valid = rst && !redirect_valid && w_room;
        imem_req_addr  = r_pc;
        w_alloc   = imem_req_valid && imem_req_ready;
        w_fill    = w_rsp && !redirect_valid && (r_drop == '0) && (w_unfilled != '0);
        w_pending = r_drop + w_unfilled;
        w_drop_d  = r_drop;
        if (redirect_valid) begin
            w_drop_d = (w_rsp && (w_pending != '0)) ? (w_pending - CNT_ONE) : w_pending;
        end else if (w_rsp && (r_drop != '0)) begin
            w_drop_d = r_drop - CNT_ONE;
        end
    end

    always_comb begin
        if_valid = w_head_ready;
        if_pc    = w_head_ready ? w_head_pc : '0;
        if_inst  = w_head_ready ? w_head_inst : NOP_INST;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc   <= RESET_PC;
            r_drop <= '0;
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_drop <= w_drop_d;
            if (redirect_valid) begin
                r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (w_alloc) begin
                r_pc <= r_pc + PC_STEP;
            end
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk          (clk),
        .rst_n        (rst),
        .i_flush      (redirect_valid),
        .i_alloc      (w_alloc),
        .i_alloc_pc   (r_pc),
        .i_fill       (w_fill),
        .i_fill_inst  (imem_rsp_data),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_unfilled   (w_unfilled),
        .o_head_ready (w_head_ready),
        .o_head_pc    (w_head_pc),
        .o_head_inst  (w_head_inst)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: reset, stall, backpressure, redirects and PC wrap.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        stall = 1'b0;
    logic        mem_hold = 1'b0;

    logic        req_valid, if_valid;
    logic [31:0] req_addr, if_pc, if_inst;
    logic        wr_req_valid, wr_if_valid;
    logic [31:0] wr_req_addr, wr_if_pc, wr_if_inst;

    int n_checks = 0;
    int n_fails  = 0;
    int n_cons   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0100), .FQ_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redir), .redirect_pc(redir_pc), .if_id_stall(stall),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FQ_DEPTH(2)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(wr_req_valid), .imem_req_ready(req_ready), .imem_req_addr(wr_req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redir), .redirect_pc(redir_pc), .if_id_stall(stall),
        .if_pc(wr_if_pc), .if_inst(wr_if_inst), .if_valid(wr_if_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_consumed(input int n, input int budget);
        int base;
        int k;
        base = n_cons;
        k = 0;
        while ((n_cons - base) < n && k < budget) begin
            cyc();
            k++;
        end
        check("consumed_within_budget", 32'(n_cons - base >= n), 32'd1);
    endtask

    // Memory: in order, one response per cycle, earliest the cycle after acceptance.
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        forever begin
            @(negedge clk);
            acc      = req_valid && req_ready;
            acc_addr = req_addr;
            @(posedge clk);
            if (!rst) mem_q.delete();
            else if (acc) mem_q.push_back(acc_addr);
            #2;
            if (!mem_hold && mem_q.size() > 0) begin
                rsp_valid = 1'b1;
                rsp_data  = mem_q.pop_front() ^ KEY;
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = '0;
            end
        end
    end

    // Monitor: every consumed instruction is matched against the expected stream.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (if_valid && !stall && !redir) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL extra_inst: got pc %h, required no instruction", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e);
                    check("if_inst", if_inst, e ^ KEY);
                    n_cons++;
                end
            end else if (!if_valid) begin
                check("bubble_inst", if_inst, NOP_INST);
                check("bubble_pc", if_pc, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x;
        #2 rst = 1'b0;
        repeat (3) cyc();
        at_neg();
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_inst", if_inst, NOP_INST);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_fetch_addr", req_addr, 32'h0000_0100);
        check("wrap_rst_addr", wr_req_addr, 32'hFFFF_FFFC);

        // Release reset with a one-cycle memory.
        cyc();
        push_stream(32'h0000_0100, 64);
        req_ready = 1'b1;
        rst = 1'b1;
        at_neg();
        check("c0_req_valid", 32'(req_valid), 32'd1);
        check("c0_req_addr", req_addr, 32'h0000_0100);
        check("wrap_c0_addr", wr_req_addr, 32'hFFFF_FFFC);
        cyc();
        at_neg();
        check("c1_req_addr", req_addr, 32'h0000_0104);
        check("c1_if_valid", 32'(if_valid), 32'd0);
        check("wrap_c1_addr", wr_req_addr, 32'h0000_0000);
        cyc();
        at_neg();
        check("c2_req_addr", req_addr, 32'h0000_0108);
        check("c2_if_valid", 32'(if_valid), 32'd1);
        check("c2_if_pc", if_pc, 32'h0000_0100);
        repeat (4) cyc();

        // Stall three cycles with the queue full.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("stall_req_valid", 32'(req_valid), 32'd0);
            check("stall_if_valid", 32'(if_valid), 32'd1);
            check("stall_if_pc", if_pc, exp_q[0]);
            check("stall_if_inst", if_inst, exp_q[0] ^ KEY);
            cyc();
        end
        stall = 1'b0;
        repeat (4) cyc();

        // Backpressure: head H presented, H+4 in flight, H+8 waiting to be requested.
        req_ready = 1'b0;
        x = exp_q[0] + 32'd8;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            check("bp_req_valid", 32'(req_valid), 32'd1);
            check("bp_req_addr", req_addr, x);
            if (i >= 2) begin
                check("bp_drained_valid", 32'(if_valid), 32'd0);
                check("bp_drained_inst", if_inst, NOP_INST);
            end
            cyc();
        end
        req_ready = 1'b1;
        wait_consumed(4, 30);
        repeat (3) cyc();

        // Redirect with two requests outstanding and unanswered.
        mem_hold = 1'b1;
        cyc();
        cyc();
        redir = 1'b1;
        redir_pc = 32'h0000_0200;
        exp_q.delete();
        push_stream(32'h0000_0200, 64);
        at_neg();
        check("redir_req_valid", 32'(req_valid), 32'd0);
        cyc();
        redir = 1'b0;
        mem_hold = 1'b0;
        wait_consumed(4, 30);
        repeat (3) cyc();

        // Redirect coinciding with a response and a stall.
        stall = 1'b1;
        redir = 1'b1;
        redir_pc = 32'h0000_0400;
        exp_q.delete();
        push_stream(32'h0000_0400, 64);
        at_neg();
        check("coinc_req_valid", 32'(req_valid), 32'd0);
        cyc();
        redir = 1'b0;
        at_neg();
        check("coinc_next_req_valid", 32'(req_valid), 32'd1);
        check("coinc_fetch_pc", req_addr, 32'h0000_0400);
        check("coinc_if_valid", 32'(if_valid), 32'd0);
        cyc();
        stall = 1'b0;
        wait_consumed(4, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 2, fetch-queue entries; power of two, 2..8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request present.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 SHALL have port imem_req_addr  output  32  fetch byte address, word aligned.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction word returned; in order, no backpressure, earliest one cycle after acceptance.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump/flush redirect from later stage.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port if_id_stall  input  1  IF/ID register holding; do not advance.
REQ-013 SHALL have port if_pc  output  32  PC of presented instruction.
REQ-014 SHALL have port if_inst  output  32  presented instruction.
REQ-015 SHALL have port if_valid  output  1  if_pc/if_inst carry a real fetched instruction.

Function
REQ-016 SHALL hold a fetch PC register; imem_req_addr = fetch PC.
REQ-017 SHALL assert imem_req_valid when queue has a free entry and redirect_valid is low.
REQ-018 SHALL, on request handshake (valid and ready), allocate the tail entry with {pc, filled=0} and advance fetch PC by 4 (wraps modulo 2^32).
REQ-019 SHALL, on imem_rsp_valid (not dropped), write imem_rsp_data into the oldest unfilled entry and set filled=1.
REQ-020 SHALL present the head entry when it is valid and filled: if_valid=1, if_pc/if_inst from head.
REQ-021 SHALL otherwise present a bubble: if_valid=0, if_inst=32'h0000_0013 (NOP), if_pc=0.
REQ-022 SHALL pop the head when presented (if_valid=1) and if_id_stall=0; pop and allocate in the same cycle are both allowed at full.
REQ-023 SHALL combinationally bypass: none; response-to-if_valid latency is one cycle (registered fill).
REQ-024 SHALL, on redirect_valid: load fetch PC with redirect_pc, invalidate all entries, issue no request that cycle.
REQ-025 SHALL keep a drop counter (width clog2(FQ_DEPTH)+1) set on redirect to the number of outstanding unfilled requests; each response while counter nonzero is discarded and decrements it.
REQ-026 SHALL treat a response coinciding with redirect as counted in the drop total, i.e. discarded.
REQ-027 SHALL, while drop counter nonzero, still issue new requests if entries free; their responses follow the dropped ones in order.
REQ-028 SHALL ignore if_id_stall when redirect_valid is high (redirect wins).
REQ-029 SHALL never overflow: outstanding + filled entries never exceed FQ_DEPTH.

Reset
REQ-030 SHALL, while rst=0, force fetch PC=RESET_PC, all entries invalid, drop counter 0, head/tail pointers 0.
REQ-031 SHALL during reset drive imem_req_valid=0, if_valid=0, if_inst=32'h0000_0013, if_pc=0.
REQ-032 SHALL discard any response arriving in the first cycle after reset release that belongs to a pre-reset request (memory is reset together; none expected).

Structure
REQ-033 SHALL take NOP encoding and instruction/address width constants from the shared core package.
REQ-034 SHALL instantiate one sub-module, fetch_queue, holding entries, pointers and fill pointer; PC and drop logic stay in if_fetch_unit.

Verification
REQ-035 SHALL cover reset: RESET_PC=0x100, release rst, ready=1, 1-cycle memory -> requests 0x100,0x104,0x108; if_pc sequence 0x100,0x104 with if_valid=1.
REQ-036 SHALL cover stall: hold if_id_stall 3 cycles with queue full -> imem_req_valid=0, if_pc constant, no entry lost; release -> order resumes.
REQ-037 SHALL cover redirect with 2 outstanding: redirect_pc=0x200 -> next two responses dropped, next presented if_pc=0x200.
REQ-038 SHALL cover redirect coincident with response and with stall -> response dropped, stall ignored, fetch PC=redirect_pc.
REQ-039 SHALL cover backpressure: imem_req_ready low 5 cycles -> addr held stable, if_valid=0 after drain, NOP presented.
REQ-040 SHALL cover wrap: RESET_PC=0xFFFF_FFFC -> addresses 0xFFFF_FFFC then 0x0000_0000.
